// File: rtl/best_arr_pkg.sv
// rtl/best_arr_pkg.sv - shared geometry constants and FSM state type for the best-array sender
package best_arr_pkg;

   localparam int DATA_WIDTH = 11;
   localparam int ROW_SIZE   = 26;
   localparam int COL_SIZE   = 19;
   localparam int BLOCKING   = 4;
   localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
   localparam int ADDR_WIDTH = $clog2(NUM_QUERYS);
   localparam int HALF       = ROW_SIZE / 2;
   localparam int XB         = (HALF + BLOCKING - 1) / BLOCKING;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/best_arr_addr_gen.sv
// rtl/best_arr_addr_gen.sv - column-blocked address walker over the two half-images of the best array
module best_arr_addr_gen #(
   parameter int ROW_SIZE   = best_arr_pkg::ROW_SIZE,
   parameter int COL_SIZE   = best_arr_pkg::COL_SIZE,
   parameter int BLOCKING   = best_arr_pkg::BLOCKING,
   parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);

   localparam int HALF = ROW_SIZE / 2;
   localparam int XB   = (HALF + BLOCKING - 1) / BLOCKING;

   localparam logic [ADDR_WIDTH-1:0] HALF_A     = ADDR_WIDTH'(HALF);
   localparam logic [ADDR_WIDTH-1:0] HALF_LAST  = ADDR_WIDTH'(HALF - 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_A      = ADDR_WIDTH'(ROW_SIZE);
   localparam logic [ADDR_WIDTH-1:0] ROW_LAST   = ADDR_WIDTH'((COL_SIZE - 1) * ROW_SIZE);
   localparam logic [ADDR_WIDTH-1:0] BLK_A      = ADDR_WIDTH'(BLOCKING);
   localparam logic [ADDR_WIDTH-1:0] BLK_LAST   = ADDR_WIDTH'(BLOCKING - 1);
   localparam logic [ADDR_WIDTH-1:0] COL_LAST   = ADDR_WIDTH'((XB - 1) * BLOCKING);

   // Loop counters are held pre-scaled (y*ROW_SIZE, x*BLOCKING) so addr is a plain sum.
   logic                  px;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [ADDR_WIDTH-1:0] col_base;
   logic [ADDR_WIDTH-1:0] xi;
   logic                  xi_end;
   logic                  y_end;
   logic                  x_end;

   always_comb begin
      // The partial last block ends early, which skips the out-of-half tuples outright.
      xi_end = (xi == BLK_LAST) || ((col_base + xi) == HALF_LAST);
      y_end  = (row_base == ROW_LAST);
      x_end  = (col_base == COL_LAST);
      last   = px & x_end & y_end & xi_end;
      addr   = (px ? HALF_A : '0) + row_base + col_base + xi;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         px       <= 1'b0;
         row_base <= '0;
         col_base <= '0;
         xi       <= '0;
      end else if (advance) begin
         if (!xi_end) begin
            xi <= xi + 1'b1;
         end else begin
            xi <= '0;
            if (!y_end) begin
               row_base <= row_base + ROW_A;
            end else begin
               row_base <= '0;
               if (!x_end) begin
                  col_base <= col_base + BLK_A;
               end else begin
                  col_base <= '0;
                  px       <= ~px;
               end
            end
         end
      end
   end

endmodule

// File: rtl/best_arr_sender.sv
// rtl/best_arr_sender.sv - streams the best-match index array from SRAM into the output FIFO
module best_arr_sender #(
   parameter int DATA_WIDTH = best_arr_pkg::DATA_WIDTH,
   parameter int ROW_SIZE   = best_arr_pkg::ROW_SIZE,
   parameter int COL_SIZE   = best_arr_pkg::COL_SIZE,
   parameter int BLOCKING   = best_arr_pkg::BLOCKING,
   parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  send_best_arr,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  out_fifo_wenq,
   output logic [DATA_WIDTH-1:0] out_fifo_wdata,
   input  logic                  out_fifo_wfull_n
);

   import best_arr_pkg::state_t;
   import best_arr_pkg::IDLE;
   import best_arr_pkg::RUN;
   import best_arr_pkg::DRAIN;
   import best_arr_pkg::DONE;

   localparam int                CW         = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]     NUM_A      = CW'(ROW_SIZE * COL_SIZE);

   state_t                state;
   logic                  inflight;
   logic [1:0]            occ;
   logic [1:0]            occ_next;
   logic [2:0]            pending;
   logic [DATA_WIDTH-1:0] buf0;
   logic [DATA_WIDTH-1:0] buf1;
   logic [CW-1:0]         word_cnt;
   logic                  cap;
   logic                  deq;
   logic                  ag_last;
   logic                  ag_clear;

   // Reset gates the strobes combinationally so an abort takes effect in the same cycle.
   always_comb begin
      cap            = inflight;
      out_fifo_wenq  = !rst && (occ != 2'd0) && out_fifo_wfull_n;
      deq            = out_fifo_wenq;
      out_fifo_wdata = buf0;
      occ_next       = occ + {1'b0, cap} - {1'b0, deq};
      pending        = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
      mem_ren        = !rst && (state == RUN) && (pending < 3'd2);
      ag_clear       = (state == IDLE) && send_best_arr;
   end

   best_arr_addr_gen #(
      .ROW_SIZE  (ROW_SIZE),
      .COL_SIZE  (COL_SIZE),
      .BLOCKING  (BLOCKING),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_addr_gen (
      .clk    (clk),
      .rst    (rst),
      .clear  (ag_clear),
      .advance(mem_ren),
      .addr   (mem_addr),
      .last   (ag_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         inflight <= 1'b0;
         occ      <= 2'd0;
         buf0     <= '0;
         buf1     <= '0;
         word_cnt <= '0;
      end else begin
         inflight <= mem_ren;
         occ      <= occ_next;
         done     <= 1'b0;

         // Head is buf0; a capture lands behind whatever survives this cycle's dequeue.
         case ({cap, deq})
            2'b11: begin
               if (occ == 2'd1) begin
                  buf0 <= mem_rdata;
               end else begin
                  buf0 <= buf1;
                  buf1 <= mem_rdata;
               end
            end
            2'b01: buf0 <= buf1;
            2'b10: begin
               if (occ == 2'd0) buf0 <= mem_rdata;
               else             buf1 <= mem_rdata;
            end
            default: ;
         endcase

         if (deq && (word_cnt != NUM_A)) word_cnt <= word_cnt + 1'b1;
         if (deq) assert (word_cnt < NUM_A);

         case (state)
            IDLE: begin
               if (send_best_arr) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  word_cnt <= '0;
               end
            end
            RUN: begin
               if (mem_ren && ag_last) state <= DRAIN;
            end
            DRAIN: begin
               if (!inflight && (occ_next == 2'd0)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               assert (word_cnt == NUM_A);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_best_arr_sender.sv
// tb/tb_best_arr_sender.sv - scoreboard bench for best_arr_sender, default and small geometries
module tb_best_arr_sender;

   localparam int DW  = 11;
   localparam int AW  = 9;
   localparam int AW6 = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           busy, done, mem_ren, wenq;
   logic           wfull_n = 1'b1;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_rdata = '0;
   logic [DW-1:0]  wdata;

   logic           start6 = 1'b0;
   logic           busy6, done6, ren6, wenq6;
   logic [AW6-1:0] addr6;
   logic [DW-1:0]  rdata6 = '0;
   logic [DW-1:0]  wdata6;

   always #5 clk = ~clk;

   best_arr_sender dut (
      .clk(clk), .rst(rst), .send_best_arr(start), .busy(busy), .done(done),
      .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_fifo_wenq(wenq), .out_fifo_wdata(wdata), .out_fifo_wfull_n(wfull_n)
   );

   best_arr_sender #(.ROW_SIZE(8), .COL_SIZE(2), .BLOCKING(3), .ADDR_WIDTH(AW6)) dut6 (
      .clk(clk), .rst(rst), .send_best_arr(start6), .busy(busy6), .done(done6),
      .mem_ren(ren6), .mem_addr(addr6), .mem_rdata(rdata6),
      .out_fifo_wenq(wenq6), .out_fifo_wdata(wdata6), .out_fifo_wfull_n(1'b1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_enq = 0, n_done = 0, n_ren = 0, n_enq6 = 0, n_done6 = 0;
   int first_wenq = 0, last_wenq = 0, done_cyc = 0, start_cyc = 0;
   int fmode = 0, stall_left = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] q6[$];

   typedef struct {
      int fmode;
      int restart_at;
      int exp_words;
      int exp_dones;
   } vec_t;
   vec_t vecs[3];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input int row, input int col, input int blk, input bit sel);
      int half = row / 2;
      int xb   = (half + blk - 1) / blk;
      for (int px = 0; px < 2; px++)
         for (int x = 0; x < xb; x++)
            for (int y = 0; y < col; y++)
               for (int xi = 0; xi < blk; xi++)
                  if (x * blk + xi < half) begin
                     if (sel) q6.push_back(DW'(px * half + y * row + x * blk + xi));
                     else     q.push_back(DW'(px * half + y * row + x * blk + xi));
                  end
   endtask

   task automatic pulse(input bit expect_accept);
      start     = 1'b1;
      start_cyc = cyc;
      if (expect_accept) push_seq(26, 19, 4, 1'b0);
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (n_done < target && k < budget) begin
         tick(1);
         k++;
      end
      check("done_within_budget", int'(n_done >= target), 1);
   endtask

   task automatic wait_enq(input int target);
      int k = 0;
      while (n_enq < target && k < 3000) begin
         tick(1);
         k++;
      end
      check("reached_word", int'(n_enq >= target), 1);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Best-array SRAM stand-ins holding mem[i] = i with one-cycle read latency.
   initial begin
      logic          r_s, r6_s;
      logic [AW-1:0] a_s;
      logic [AW6-1:0] a6_s;
      forever begin
         @(negedge clk);
         r_s = mem_ren; a_s = mem_addr; r6_s = ren6; a6_s = addr6;
         @(posedge clk);
         #1;
         if (r_s)  mem_rdata = DW'(a_s);
         if (r6_s) rdata6    = DW'(a6_s);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (fmode)
            0:       wfull_n = 1'b1;
            1:       wfull_n = ($urandom_range(0, 1) == 1);
            default: begin
               wfull_n = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (rst) check("quiet_in_reset", int'({wenq, mem_ren}), 0);
      if (mem_ren) n_ren++;
      if (wenq) begin
         check("wenq_only_when_not_full", int'(wfull_n), 1);
         if (q.size() == 0) check("unexpected_word", int'(wdata), -1);
         else begin
            e = q.pop_front();
            check("word", int'(wdata), int'(e));
         end
         if (n_enq == 0) first_wenq = cyc;
         last_wenq = cyc;
         n_enq++;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (wenq6) begin
         if (q6.size() == 0) check("unexpected_word6", int'(wdata6), -1);
         else begin
            e = q6.pop_front();
            check("word6", int'(wdata6), int'(e));
         end
         n_enq6++;
      end
      if (done6) n_done6++;
   end

   initial begin
      vecs[0] = '{fmode: 0, restart_at: -1,  exp_words: 494, exp_dones: 1};
      vecs[1] = '{fmode: 1, restart_at: -1,  exp_words: 494, exp_dones: 1};
      vecs[2] = '{fmode: 0, restart_at: 100, exp_words: 494, exp_dones: 1};

      tick(3);
      check("rst_busy",  int'(busy), 0);
      check("rst_done",  int'(done), 0);
      check("rst_ren",   int'(mem_ren), 0);
      check("rst_addr",  int'(mem_addr), 0);
      check("rst_wenq",  int'(wenq), 0);
      check("rst_wdata", int'(wdata), 0);
      rst = 1'b0;
      tick(2);

      for (int v = 0; v < 3; v++) begin
         fmode  = vecs[v].fmode;
         n_enq  = 0;
         n_done = 0;
         tick(1);
         pulse(1'b1);
         if (vecs[v].restart_at >= 0) begin
            wait_enq(vecs[v].restart_at);
            check("busy_mid_transfer", int'(busy), 1);
            pulse(1'b0);
         end
         wait_done(1, 4000);
         tick(5);
         check("word_count", n_enq, vecs[v].exp_words);
         check("done_count", n_done, vecs[v].exp_dones);
         check("queue_drained", q.size(), 0);
         check("idle_after", int'(busy), 0);
         if (v == 0) begin
            check("first_wenq_latency", first_wenq - start_cyc, 3);
            check("done_after_last", done_cyc - last_wenq, 1);
         end
      end

      // Backpressure held right after start.
      fmode      = 2;
      stall_left = 21;
      n_enq = 0; n_done = 0; n_ren = 0;
      tick(1);
      pulse(1'b1);
      tick(12);
      check("stall_reads", n_ren, 2);
      check("stall_enq", n_enq, 0);
      wait_done(1, 4000);
      tick(5);
      check("stall_word_count", n_enq, 494);
      check("stall_done_count", n_done, 1);
      check("stall_queue_drained", q.size(), 0);

      // Reset in the middle of a transfer, then a clean restart.
      fmode = 0;
      n_enq = 0; n_done = 0;
      tick(1);
      pulse(1'b1);
      wait_enq(250);
      rst = 1'b1;
      q.delete();
      tick(1);
      check("abort_busy",  int'(busy), 0);
      check("abort_ren",   int'(mem_ren), 0);
      check("abort_addr",  int'(mem_addr), 0);
      check("abort_wenq",  int'(wenq), 0);
      check("abort_wdata", int'(wdata), 0);
      check("abort_done",  int'(done), 0);
      tick(1);
      rst = 1'b0;
      tick(10);
      check("no_done_after_abort", n_done, 0);
      n_enq = 0;
      pulse(1'b1);
      wait_done(1, 4000);
      tick(5);
      check("restart_word_count", n_enq, 494);
      check("restart_done_count", n_done, 1);
      check("restart_queue_drained", q.size(), 0);

      // Small geometry: ROW_SIZE=8, COL_SIZE=2, BLOCKING=3.
      begin
         int k = 0;
         start6 = 1'b1;
         push_seq(8, 2, 3, 1'b1);
         tick(1);
         start6 = 1'b0;
         while (n_done6 < 1 && k < 200) begin
            tick(1);
            k++;
         end
         tick(3);
         check("small_word_count", n_enq6, 16);
         check("small_done_count", n_done6, 1);
         check("small_queue_drained", q6.size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
